// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serialises one command into a byte frame, then collects the response bytes.
// Latency: first frame byte is presented the cycle after acceptance; rsp_valid pulses the cycle after the final byte or timeout.
// Backpressure: tx_ready stalls the frame (byte held stable); rx_valid has no backpressure and is ignored outside WAIT_RSP.
module uart_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int OP_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH-1:0]   cmd_op_a,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [OP_WIDTH-1:0]     cmd_fun,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [DATA_WIDTH-1:0] HDR_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU2 = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU0 = DATA_WIDTH'(8'hDD);

  logic [1:0]            state;
  // body[k] is frame byte k+1; the header goes straight into tx_data on acceptance
  logic [DATA_WIDTH-1:0] body [3];
  logic [1:0]            pos;        // index of the frame byte currently on tx_data
  logic [1:0]            last_pos;   // index of the final frame byte
  logic [1:0]            rsp_need;   // response bytes expected
  logic [1:0]            rsp_cnt;    // response bytes collected so far
  logic [DATA_WIDTH-1:0] rsp_lo;
  logic [DATA_WIDTH-1:0] rsp_hi;
  logic [CW-1:0]         idle_cnt;

  logic [DATA_WIDTH-1:0]   addr_ext;
  logic [DATA_WIDTH-1:0]   fun_ext;
  logic [2*DATA_WIDTH-1:0] rsp_with_byte;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign addr_ext  = DATA_WIDTH'(cmd_addr);
  assign fun_ext   = DATA_WIDTH'(cmd_fun);
  // Response image including the byte arriving this cycle; the unfilled high byte is already zero
  assign rsp_with_byte = (rsp_cnt == 2'd0) ? {rsp_hi, rx_data} : {rx_data, rsp_lo};

  // Command latch, frame sequencing, response collection and timeout
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      pos         <= '0;
      last_pos    <= '0;
      rsp_need    <= '0;
      rsp_cnt     <= '0;
      rsp_lo      <= '0;
      rsp_hi      <= '0;
      idle_cnt    <= '0;
      for (int i = 0; i < 3; i++) body[i] <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_type)
              2'd0: begin
                tx_data  <= HDR_WR;
                body[0]  <= addr_ext;
                body[1]  <= cmd_wdata;
                body[2]  <= '0;
                last_pos <= 2'd2;
                rsp_need <= 2'd0;
              end
              2'd1: begin
                tx_data  <= HDR_RD;
                body[0]  <= addr_ext;
                body[1]  <= '0;
                body[2]  <= '0;
                last_pos <= 2'd1;
                rsp_need <= 2'd1;
              end
              2'd2: begin
                tx_data  <= HDR_ALU2;
                body[0]  <= cmd_op_a;
                body[1]  <= cmd_op_b;
                body[2]  <= fun_ext;
                last_pos <= 2'd3;
                rsp_need <= 2'd2;
              end
              default: begin
                tx_data  <= HDR_ALU0;
                body[0]  <= fun_ext;
                body[1]  <= '0;
                body[2]  <= '0;
                last_pos <= 2'd1;
                rsp_need <= 2'd2;
              end
            endcase
            tx_valid <= 1'b1;
            pos      <= '0;
            rsp_cnt  <= '0;
            rsp_lo   <= '0;
            rsp_hi   <= '0;
            idle_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (pos == last_pos) begin
              tx_valid <= 1'b0;
              if (rsp_need == 2'd0) begin
                state     <= DONE;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
              end else begin
                state <= WAIT_RSP;
              end
            end else begin
              // next byte presented back-to-back
              tx_data <= body[pos];
              pos     <= pos + 2'd1;
            end
          end
        end
        WAIT_RSP: begin
          if (rx_valid) begin
            // an arriving byte always beats a coincident expiry
            idle_cnt <= '0;
            if (rsp_cnt == 2'd0) rsp_lo <= rx_data;
            else                 rsp_hi <= rx_data;
            rsp_cnt <= rsp_cnt + 2'd1;
            if (2'(rsp_cnt + 2'd1) == rsp_need) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_data  <= rsp_with_byte;
            end
          end else if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_data    <= {rsp_hi, rsp_lo};
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: queue-based protocol model plus directed command scenarios.
// Latency: model advances on each rising edge; DUT outputs are compared on every falling edge.
// Backpressure: tx_ready patterns and stray/surplus rx bytes are driven from the stimulus block.
module tb_uart_cmd_master;

  localparam int TMO = 24;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = '0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [7:0] cmd_op_a = '0;
  logic [7:0] cmd_op_b = '0;
  logic [3:0] cmd_fun = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rsp_valid;
  logic [15:0] rsp_data;
  logic       rsp_timeout;
  logic       busy;

  uart_cmd_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .OP_WIDTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a),
    .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_SEND = 1, P_WAIT = 2, P_DONE = 3;
  int          ph = P_IDLE;
  logic [7:0]  tx_q[$];     // frame bytes still owed to the UART TX
  logic [7:0]  got[$];      // response bytes accepted so far
  logic [7:0]  tx_log[$];   // bytes actually transferred, for literal checks
  int          need = 0;
  int          idle = 0;
  logic        m_tmo = 1'b0;
  logic [15:0] m_hold = '0; // what rsp_data must show
  bit          stalled = 1'b0;
  bit          just_xfer = 1'b0;
  logic [7:0]  st_data = '0;

  task automatic finish_rsp(input logic t);
    m_tmo  = t;
    m_hold = {(got.size() > 1) ? got[1] : 8'h00, (got.size() > 0) ? got[0] : 8'h00};
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      ph = P_IDLE; tx_q.delete(); got.delete();
      stalled = 0; just_xfer = 0; m_hold = '0; m_tmo = 0;
    end else begin
      stalled = 0; just_xfer = 0;
      case (ph)
        P_IDLE: if (cmd_valid) begin
          got.delete();
          case (cmd_type)
            2'd0: begin tx_q = '{8'hAA, {4'h0, cmd_addr}, cmd_wdata}; need = 0; end
            2'd1: begin tx_q = '{8'hBB, {4'h0, cmd_addr}}; need = 1; end
            2'd2: begin tx_q = '{8'hCC, cmd_op_a, cmd_op_b, {4'h0, cmd_fun}}; need = 2; end
            default: begin tx_q = '{8'hDD, {4'h0, cmd_fun}}; need = 2; end
          endcase
          ph = P_SEND;
        end
        P_SEND: begin
          if (tx_valid && tx_ready) begin
            tx_log.push_back(tx_data);
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() == 0) begin
              idle = 0;
              if (need == 0) begin ph = P_DONE; finish_rsp(1'b0); end
              else ph = P_WAIT;
            end else just_xfer = 1;
          end else if (tx_valid) begin
            stalled = 1; st_data = tx_data;
          end
        end
        P_WAIT: begin
          if (rx_valid) begin
            got.push_back(rx_data); idle = 0;
            if (got.size() == need) begin ph = P_DONE; finish_rsp(1'b0); end
          end else begin
            idle++;
            if (idle == TMO) begin ph = P_DONE; finish_rsp(1'b1); end
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, ph == P_IDLE});
      chk("busy", {31'b0, busy}, {31'b0, ph != P_IDLE});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ph == P_DONE});
      chk("rsp_data", {16'b0, rsp_data}, {16'b0, m_hold});
      if (ph == P_DONE) chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, m_tmo});
      if (ph != P_SEND) chk("tx_valid_idle", {31'b0, tx_valid}, 32'd0);
      else begin
        if (!just_xfer) chk("tx_valid_send", {31'b0, tx_valid}, 32'd1);
        if (stalled) chk("tx_data_stall", {24'b0, tx_data}, {24'b0, st_data});
        if (tx_valid && tx_q.size() > 0) chk("tx_data", {24'b0, tx_data}, {24'b0, tx_q[0]});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] w,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    tx_log.delete();
    cmd_type = t; cmd_addr = a; cmd_wdata = w; cmd_op_a = oa; cmd_op_b = ob; cmd_fun = f;
    cmd_valid = 1'b1;
    @(negedge CLK);
    // scramble fields after acceptance: the DUT must use its latched copy
    cmd_valid = 1'b0;
    cmd_type = ~t; cmd_addr = ~a; cmd_wdata = ~w; cmd_op_a = ~oa; cmd_op_b = ~ob; cmd_fun = ~f;
  endtask

  task automatic rx(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic wait_frame(input int n);
    int k = 0;
    while (tx_log.size() < n && k < 100) begin @(negedge CLK); k++; end
    chk("frame_done", {31'b0, tx_log.size() >= n}, 32'd1);
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 200) begin @(negedge CLK); cycles++; end
    chk("rsp_seen", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic chk_log(input string nm, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e[4];
    e = '{b0, b1, b2, b3};
    chk({nm, "_len"}, tx_log.size(), n);
    for (int i = 0; i < n && i < tx_log.size(); i++) chk({nm, "_byte"}, {24'b0, tx_log[i]}, {24'b0, e[i]});
  endtask

  logic pat[4];

  initial begin
    int cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
    chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk_en = 1'b1;
    RST = 1'b0;
    @(negedge CLK);

    // Type 0 write, tx_ready tied high
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    wait_rsp(cyc);
    chk("t0_rsp", {16'b0, rsp_data}, 32'h0000);
    chk("t0_tmo", {31'b0, rsp_timeout}, 32'd0);
    chk_log("t0_tx", 3, 8'hAA, 8'h05, 8'h3C, 8'h00);
    @(negedge CLK);

    // Type 1 read, response 20 cycles after the frame; cmd_valid pulsed while busy
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_frame(2);
    cmd_type = 2'd0; cmd_valid = 1'b1;
    repeat (3) @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (17) @(negedge CLK);
    rx(8'h7E);
    wait_rsp(cyc);
    chk("t1_rsp", {16'b0, rsp_data}, 32'h007E);
    chk("t1_tmo", {31'b0, rsp_timeout}, 32'd0);
    chk_log("t1_tx", 2, 8'hBB, 8'h02, 8'h00, 8'h00);
    @(negedge CLK);

    // Type 2 ALU, tx_ready toggling 1-0-0-1
    issue(2'd2, 4'h0, 8'h00, 8'h0F, 8'h11, 4'h2);
    for (int i = 0; i < 60 && tx_log.size() < 4; i++) begin
      tx_ready = pat[i % 4];
      @(negedge CLK);
    end
    tx_ready = 1'b1;
    wait_frame(4);
    rx(8'hFF);
    rx(8'h00);
    wait_rsp(cyc);
    chk("t2_rsp", {16'b0, rsp_data}, 32'h00FF);
    chk_log("t2_tx", 4, 8'hCC, 8'h0F, 8'h11, 8'h02);
    @(negedge CLK);

    // Type 3, only one response byte: timeout after TMO idle cycles
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1);
    wait_frame(2);
    rx(8'h34);
    wait_rsp(cyc);
    chk("t3_tmo_latency", cyc, TMO);
    chk("t3_rsp", {16'b0, rsp_data}, 32'h0034);
    chk("t3_tmo", {31'b0, rsp_timeout}, 32'd1);
    chk_log("t3_tx", 2, 8'hDD, 8'h01, 8'h00, 8'h00);
    @(negedge CLK);

    // Response byte lands on the very cycle the timeout would expire: byte wins
    issue(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_frame(2);
    repeat (TMO - 1) @(negedge CLK);
    rx(8'hA5);
    wait_rsp(cyc);
    chk("edge_rsp", {16'b0, rsp_data}, 32'h00A5);
    chk("edge_tmo", {31'b0, rsp_timeout}, 32'd0);
    @(negedge CLK);

    // Stray rx in IDLE and during SEND are discarded; surplus after DONE is ignored
    rx(8'h66);
    issue(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
    rx(8'h55);
    wait_frame(2);
    rx(8'h99);
    wait_rsp(cyc);
    chk("stray_rsp", {16'b0, rsp_data}, 32'h0099);
    @(negedge CLK);
    rx(8'h77);
    repeat (2) @(negedge CLK);
    chk("stray_hold", {16'b0, rsp_data}, 32'h0099);

    // Reset during the second byte of a type 2 frame
    issue(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h5);
    @(negedge CLK);
    tx_ready = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    RST = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge CLK);
    issue(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_frame(2);
    rx(8'h42);
    wait_rsp(cyc);
    chk("post_rst_rsp", {16'b0, rsp_data}, 32'h0042);
    chk_log("post_rst_tx", 2, 8'hBB, 8'h07, 8'h00, 8'h00);
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
